// File: rtl/sr_instr_encoder.sv
// RV32I instruction encoder for the schoolRISCV subset: symbolic requests in,
// range-checked machine words out, tagged with a sequential imem word address.
module sr_instr_encoder #(
    parameter int AW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    input  logic          clr
);

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_U  = 7'b0110111;
    localparam logic [6:0] OPC_B  = 7'b1100011;
    localparam logic [6:0] OPC_S  = 7'b0100011;

    logic          r_valid;
    logic [31:0]   r_instr;
    logic [AW-1:0] r_addr;
    logic          r_err;
    logic [CW-1:0] r_err_cnt;

    logic [31:0]   w_instr;
    logic          w_legal;
    logic          w_acc;
    logic          w_hs;
    logic          w_reject;
    logic          w_cnt_sat;

    function automatic logic f_in_range(input logic [31:0] imm,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

    function automatic logic [31:0] f_enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, OPC_R};
    endfunction

    function automatic logic [31:0] f_enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [4:0] rs1);
        return {imm, rs1, f3, rd, OPC_I};
    endfunction

    function automatic logic [31:0] f_enc_b(input logic [31:0] imm, input logic [2:0] f3,
                                            input logic [4:0] rs1, input logic [4:0] rs2);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_B};
    endfunction

    assign w_acc     = in_valid & in_ready;
    assign w_hs      = r_valid & out_ready;
    assign w_reject  = w_acc & ~w_legal;
    assign w_cnt_sat = &r_err_cnt;

    // Encode the requested operation and decide whether its immediate is legal.
    always_comb begin
        w_instr = 32'h0000_0000;
        w_legal = 1'b0;
        case (in_op)
            5'd0:  begin w_instr = f_enc_r(7'b0000000, 3'b000, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd1:  begin w_instr = f_enc_r(7'b0000000, 3'b110, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd2:  begin w_instr = f_enc_r(7'b0000000, 3'b101, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd3:  begin w_instr = f_enc_r(7'b0000000, 3'b011, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd4:  begin w_instr = f_enc_r(7'b0100000, 3'b000, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd5:  begin w_instr = f_enc_r(7'b0000000, 3'b111, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd6:  begin w_instr = f_enc_r(7'b0000000, 3'b001, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd7:  begin w_instr = f_enc_r(7'b0000000, 3'b100, in_rd, in_rs1, in_rs2); w_legal = 1'b1; end
            5'd8:  begin
                w_instr = f_enc_i({7'b0000000, in_imm[4:0]}, 3'b001, in_rd, in_rs1);
                w_legal = f_in_range(in_imm, 32'sd0, 32'sd31);
            end
            5'd9:  begin
                w_instr = f_enc_i({7'b0000000, in_imm[4:0]}, 3'b101, in_rd, in_rs1);
                w_legal = f_in_range(in_imm, 32'sd0, 32'sd31);
            end
            5'd10: begin
                w_instr = f_enc_i(in_imm[11:0], 3'b000, in_rd, in_rs1);
                w_legal = f_in_range(in_imm, -32'sd2048, 32'sd2047);
            end
            5'd11: begin
                w_instr = f_enc_i(in_imm[11:0], 3'b111, in_rd, in_rs1);
                w_legal = f_in_range(in_imm, -32'sd2048, 32'sd2047);
            end
            5'd12: begin
                w_instr = f_enc_i(in_imm[11:0], 3'b100, in_rd, in_rs1);
                w_legal = f_in_range(in_imm, -32'sd2048, 32'sd2047);
            end
            5'd13: begin
                w_instr = f_enc_i(in_imm[11:0], 3'b110, in_rd, in_rs1);
                w_legal = f_in_range(in_imm, -32'sd2048, 32'sd2047);
            end
            5'd14: begin
                w_instr = {in_imm[31:12], in_rd, OPC_U};
                w_legal = (in_imm[11:0] == 12'h000);
            end
            5'd15: begin
                w_instr = f_enc_b(in_imm, 3'b000, in_rs1, in_rs2);
                w_legal = f_in_range(in_imm, -32'sd4096, 32'sd4094) & ~in_imm[0];
            end
            5'd16: begin
                w_instr = f_enc_b(in_imm, 3'b101, in_rs1, in_rs2);
                w_legal = f_in_range(in_imm, -32'sd4096, 32'sd4094) & ~in_imm[0];
            end
            5'd17: begin
                w_instr = f_enc_b(in_imm, 3'b001, in_rs1, in_rs2);
                w_legal = f_in_range(in_imm, -32'sd4096, 32'sd4094) & ~in_imm[0];
            end
            5'd18: begin
                w_instr = f_enc_b(in_imm, 3'b100, in_rs1, in_rs2);
                w_legal = f_in_range(in_imm, -32'sd4096, 32'sd4094) & ~in_imm[0];
            end
            5'd19: begin
                w_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_S};
                w_legal = f_in_range(in_imm, -32'sd2048, 32'sd2047);
            end
            default: begin
                w_instr = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    // Output register stage: a rejected request leaves the stage empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= 32'h0000_0000;
        end else begin
            if (w_acc) begin
                r_valid <= w_legal;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_acc && w_legal) begin
                r_instr <= w_instr;
            end
        end
    end

    // Address counter and error bookkeeping; clr outranks a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (clr) begin
                r_addr <= '0;
            end else if (w_hs) begin
                r_addr <= r_addr + AW'(1);
            end
            if (clr) begin
                r_err     <= w_reject;
                r_err_cnt <= CW'(w_reject);
            end else if (w_reject) begin
                r_err <= 1'b1;
                if (!w_cnt_sat) begin
                    r_err_cnt <= r_err_cnt + CW'(1);
                end
            end
        end
    end

    assign in_ready  = ~r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_addr  = r_addr;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_sr_instr_encoder.sv
// Directed bench for sr_instr_encoder: a default-width instance for encoding,
// rejection and back-pressure, and a narrow instance for wrap, clr and saturation.
module tb_sr_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_ready;
    logic        clr;

    logic        a_in_ready, a_out_valid, a_err;
    logic [31:0] a_out_instr;
    logic [7:0]  a_out_addr, a_err_cnt;
    logic        b_in_ready, b_out_valid, b_err;
    logic [31:0] b_out_instr;
    logic [1:0]  b_out_addr, b_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] wrap_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    always #5 clk = ~clk;

    sr_instr_encoder #(.AW(8), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
        .out_addr(a_out_addr), .err(a_err), .err_cnt(a_err_cnt), .clr(clr)
    );

    sr_instr_encoder #(.AW(2), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
        .out_addr(b_out_addr), .err(b_err), .err_cnt(b_err_cnt), .clr(clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for one clock edge, then sample #1 after that edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_a(input string tag, input logic [31:0] instr, input logic [7:0] addr);
        check({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        check({tag, ".instr"}, a_out_instr, instr);
        check({tag, ".addr"},  32'(a_out_addr), 32'(addr));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 5'd0; in_rd = 5'd0; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_imm = 32'd0; out_ready = 1'b1; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid",   32'(a_out_valid), 32'd0);
        check("rst.instr",   a_out_instr, 32'h0);
        check("rst.err",     32'(a_err), 32'd0);
        check("rst.err_cnt", 32'(a_err_cnt), 32'd0);
        check("rst.ready",   32'(a_in_ready), 32'd1);
        rst = 1'b0;

        send(5'd0,  5'd3, 5'd1, 5'd2, 32'd0);          expect_a("add",  32'h002081B3, 8'd0);
        send(5'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);  expect_a("addi", 32'hFFF00093, 8'd1);
        send(5'd19, 5'd0, 5'd1, 5'd2, 32'd8);          expect_a("sw",   32'h0020A423, 8'd2);
        send(5'd15, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);  expect_a("beq",  32'hFE208EE3, 8'd3);
        send(5'd14, 5'd5, 5'd0, 5'd0, 32'h1234_5000);  expect_a("lui",  32'h123452B7, 8'd4);
        send(5'd4,  5'd3, 5'd1, 5'd2, 32'd0);          expect_a("sub",  32'h402081B3, 8'd5);
        send(5'd8,  5'd1, 5'd2, 5'd0, 32'd31);         expect_a("slli", 32'h01F11093, 8'd6);

        send(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
        check("rej.valid", 32'(a_out_valid), 32'd0);
        check("rej.err",   32'(a_err), 32'd1);
        send(5'd17, 5'd0, 5'd1, 5'd2, 32'd3);
        send(5'd14, 5'd5, 5'd0, 5'd0, 32'h0000_1001);
        send(5'd25, 5'd1, 5'd1, 5'd1, 32'd0);
        check("rej.err_cnt4", 32'(a_err_cnt), 32'd4);
        check("rej.valid2",   32'(a_out_valid), 32'd0);
        send(5'd9,  5'd1, 5'd1, 5'd0, 32'd32);
        check("rej.err_cnt5", 32'(a_err_cnt), 32'd5);
        send(5'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);  expect_a("addi_min", 32'h80000093, 8'd7);
        @(posedge clk); #1;
        check("drain.valid", 32'(a_out_valid), 32'd0);

        out_ready = 1'b0;
        send(5'd1, 5'd4, 5'd1, 5'd2, 32'd0);            expect_a("bp.or", 32'h0020E233, 8'd8);
        @(negedge clk);
        in_op = 5'd7; in_rd = 5'd5; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'd0;
        in_valid = 1'b1;
        #1;
        check("bp.ready0", 32'(a_in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_a("bp.hold", 32'h0020E233, 8'd8);
        check("bp.ready1", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_a("bp.xor", 32'h0020C2B3, 8'd9);
        @(posedge clk); #1;
        check("bp.drain", 32'(a_out_valid), 32'd0);

        out_ready = 1'b0;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);           expect_a("pre_rst", 32'h002081B3, 8'd10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst2.valid",   32'(a_out_valid), 32'd0);
        check("rst2.err",     32'(a_err), 32'd0);
        check("rst2.err_cnt", 32'(a_err_cnt), 32'd0);
        check("rst2.addr",    32'(a_out_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
            check($sformatf("wrap%0d.addr", i), 32'(b_out_addr), 32'(wrap_exp[i]));
        end
        send(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
        check("b.rej.err", 32'(b_err), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr.err",     32'(b_err), 32'd0);
        check("clr.err_cnt", 32'(b_err_cnt), 32'd0);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        check("clr.addr", 32'(b_out_addr), 32'd0);
        clr = 1'b1;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        clr = 1'b0;
        check("clr_hs.addr",  32'(b_out_addr), 32'd0);
        check("clr_hs.valid", 32'(b_out_valid), 32'd1);

        for (int i = 0; i < 5; i++) begin
            send(5'd25, 5'd0, 5'd0, 5'd0, 32'd0);
        end
        check("sat.err_cnt", 32'(b_err_cnt), 32'd3);
        check("sat.err",     32'(b_err), 32'd1);
        clr = 1'b1;
        send(5'd25, 5'd0, 5'd0, 5'd0, 32'd0);
        clr = 1'b0;
        check("clr_rej.err",     32'(b_err), 32'd1);
        check("clr_rej.err_cnt", 32'(b_err_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_instr_encoder.md
# sr_instr_encoder

Sequential RV32I instruction encoder: the encoding counterpart of the schoolRISCV control decoder. It accepts symbolic instruction requests (operation select, register indices, immediate) over a valid/ready handshake and emits the 32-bit machine word together with a sequential instruction-memory word address. It covers exactly the instruction subset the core decodes. It sits between a host-side program loader (UART/debug bridge) and the instruction-memory write port, and range-checks immediates so that illegal requests never reach memory.

## Interface
Parameters:
- AW, 8, instruction-memory word-address width.
- CW, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  5  operation select: 0 ADD, 1 OR, 2 SRL, 3 SLTU, 4 SUB, 5 AND, 6 SLL, 7 XOR, 8 SLLI, 9 SRLI, 10 ADDI, 11 ANDI, 12 XORI, 13 ORI, 14 LUI, 15 BEQ, 16 BGE, 17 BNE, 18 BLT, 19 SW; 20–31 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields are ignored.
- in_imm  in  32  immediate as a full signed value: byte offset for branches, full upper value for LUI.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  AW  word address for out_instr.
- err  out  1  sticky; at least one request has been rejected.
- err_cnt  out  CW  rejected-request count; saturates at all-ones.
- clr  in  1  synchronous: clears the address counter, err and err_cnt.

## Operation
- Formats use standard RV32I fields.
  - R (opcode 0110011): funct3 is ADD/SUB 000, SLL 001, SLTU 011, XOR 100, SRL 101, OR 110, AND 111. funct7 is 0100000 for SUB and 0 otherwise.
  - I (0010011): ADDI 000, XORI 100, ORI 110, ANDI 111, SLLI 001, SRLI 101. For SLLI/SRLI, instr[31:25]=0 and instr[24:20]=shamt.
  - U: LUI opcode 0110111.
  - B (1100011): BEQ 000, BNE 001, BLT 100, BGE 101.
  - S (0100011): SW 010.
- Validity checks. A request that fails any check is rejected.
  - I-type arithmetic: in_imm must lie in −2048..2047.
  - Shifts: 0..31.
  - SW: −2048..2047.
  - Branch: −4096..4094, and bit0 must be 0.
  - LUI: in_imm[11:0] must be 0.
  - in_op must be ≤ 19.
- Rejection handling: no output is produced, err is set, err_cnt increments (saturating), and out_addr does not advance.
- Structure: a single output register stage.
  - in_ready = !out_valid | out_ready. This gives full throughput with no bubble under continuous out_ready.
  - On an accepted valid request: out_instr and out_valid=1 load next cycle.
  - On an accepted rejected request: out_valid=0 next cycle, unless a previous word is still held, which cannot occur because acceptance implies the register is free or draining.
- Address counter, addr_q:
  - out_addr = addr_q while out_valid.
  - addr_q increments on each output handshake and wraps from 2^AW−1 to 0 with no flag.
- clr:
  - Sets addr_q=0, err=0, err_cnt=0 next cycle.
  - A word held in the output register keeps its data but is re-addressed to 0.
  - If a handshake and clr occur in the same cycle, clr wins and addr_q becomes 0.
  - A rejection in the same cycle as clr leaves err=1 and err_cnt=1.
- Reset (rst=1 at a clock edge): out_valid=0, out_instr=0, addr_q=0, err=0, err_cnt=0. in_ready=1 after reset. A request presented during reset is discarded.

## Timing
- Latency: request accepted at edge N → out_valid=1 with out_instr visible after edge N, stable until its handshake.
- Holding: while out_valid & !out_ready, out_instr and out_addr are held and in_ready=0.
- Back-to-back: with out_ready=1, one word per cycle, with addresses consecutive.
- err/err_cnt update at the edge following acceptance of the rejected request.
- Outputs are registered except in_ready, which is combinational from out_valid/out_ready.

## Test plan
- After reset, with out_ready=1: ADD rd=3 rs1=1 rs2=2 → 0x002081B3 at addr 0; then ADDI rd=1 rs1=0 imm=−1 → 0xFFF00093 at addr 1.
- SW rs1=1 rs2=2 imm=8 → 0x0020A423. BEQ rs1=1 rs2=2 imm=−4 → 0xFE208EE3. LUI rd=5 imm=0x12345000 → 0x123452B7. SUB rd=3 rs1=1 rs2=2 → 0x402081B3.
- Rejections: ADDI imm=2048, BNE imm=3, LUI imm=0x1001, op=25 → no output, err=1, err_cnt=4, next valid word at an unchanged address.
- Back-pressure: out_ready=0 with two requests queued → first word held stable and in_ready=0. After out_ready=1: two words at consecutive addresses, no loss or duplicate.
- Wrap: AW=2, five valid requests → addresses 0,1,2,3,0. clr mid-stream → next address 0, err and err_cnt cleared.
- Saturation and reset: CW=2, five rejections → err_cnt=3. Assert rst while out_valid=1 → out_valid=0, err=0 and err_cnt=0 the following cycle.
